// File: rtl/mem_port_arbiter.sv
// Serialises the instruction-fetch and data ports onto one unified-cache port and returns both responses together.
// Optional fetch-reuse path is compiled in when ARB_IFETCH_REUSE_EN is defined.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_read,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_rdata,
    output logic        icache_resp,
    input  logic        dcache_read,
    input  logic        dcache_write,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    input  logic [3:0]  dcache_byte_enable,
    output logic [31:0] dcache_rdata,
    output logic        dcache_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t      state;
    logic        done_i;
    logic        done_d;
    logic [31:0] buf_i;
    logic [31:0] buf_d;
    logic [31:0] i_addr_q;

    logic act_i;
    logic act_d;
    logic i_match;
    logic i_hit;
    logic i_mem_done;
    logic d_mem_done;
    logic reuse_hit;
    logic cmp_i;
    logic cmp_d;
    logic advance;
    logic need_i;
    logic need_d;

    assign act_i      = icache_read;
    assign act_d      = dcache_read | dcache_write;
    // A buffered or in-flight fetch only counts if the datapath still wants that address.
    assign i_match    = (icache_addr == i_addr_q);
    assign i_hit      = done_i & i_match;
    assign i_mem_done = (state == GRANT_I) & mem_resp & i_match;
    assign d_mem_done = (state == GRANT_D) & mem_resp;

`ifdef ARB_IFETCH_REUSE_EN
    logic [31:0] last_i_addr;
    logic [31:0] last_i_data;
    logic        reuse_valid;

    assign reuse_hit    = act_i & reuse_valid & (icache_addr == last_i_addr);
    assign icache_rdata = i_hit ? buf_i : (reuse_hit ? last_i_data : mem_rdata);

    // Remember the last fetched word; a store to that word makes it stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_valid <= 1'b0;
            last_i_addr <= 32'd0;
            last_i_data <= 32'd0;
        end else if (i_mem_done) begin
            reuse_valid <= 1'b1;
            last_i_addr <= i_addr_q;
            last_i_data <= mem_rdata;
        end else if ((state == IDLE) && need_d && dcache_write &&
                     (dcache_addr[31:2] == last_i_addr[31:2])) begin
            reuse_valid <= 1'b0;
        end
    end
`else
    assign reuse_hit    = 1'b0;
    assign icache_rdata = i_hit ? buf_i : mem_rdata;
`endif

    assign cmp_i        = i_hit | i_mem_done | reuse_hit;
    assign cmp_d        = done_d | d_mem_done;
    assign advance      = (act_i | act_d) & (~act_i | cmp_i) & (~act_d | cmp_d);
    assign icache_resp  = advance & act_i;
    assign dcache_resp  = advance & act_d;
    assign dcache_rdata = done_d ? buf_d : mem_rdata;
    assign need_i       = act_i & ~cmp_i;
    assign need_d       = act_d & ~done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            done_i          <= 1'b0;
            done_d          <= 1'b0;
            buf_i           <= 32'd0;
            buf_d           <= 32'd0;
            i_addr_q        <= 32'd0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_byte_enable <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Data first: it belongs to the older instruction.
                    if (need_d) begin
                        state           <= GRANT_D;
                        mem_read        <= dcache_read;
                        mem_write       <= dcache_write;
                        mem_addr        <= dcache_addr;
                        mem_wdata       <= dcache_wdata;
                        mem_byte_enable <= dcache_byte_enable;
                    end else if (need_i) begin
                        state           <= GRANT_I;
                        mem_read        <= 1'b1;
                        mem_write       <= 1'b0;
                        mem_addr        <= icache_addr;
                        mem_wdata       <= 32'd0;
                        mem_byte_enable <= 4'd0;
                        i_addr_q        <= icache_addr;
                    end
                end
                GRANT_I: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (i_match) begin
                            buf_i  <= mem_rdata;
                            done_i <= 1'b1;
                        end
                    end
                end
                GRANT_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        buf_d     <= mem_rdata;
                        done_d    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done_i && !i_match) begin
                done_i <= 1'b0;
            end
            if (advance) begin
                done_i <= 1'b0;
                done_d <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Serialises the datapath's two memory ports (instruction fetch and data load/store) onto one unified-cache port. It sits directly downstream of the pipelined datapath and upstream of the unified cache. The datapath stalls until every active port has responded, so the arbiter buffers the first completion and returns both responses in the same cycle. This lets the pipeline advance exactly once per joint completion.

## Interface
Parameters: none. All widths are fixed by rv32i_word (32 bits).

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- icache_read  in  1  fetch request, held until icache_resp
- icache_addr  in  32  fetch address; may change mid-request (branch redirect)
- icache_rdata  out  32  fetched word, valid when icache_resp
- icache_resp  out  1  fetch complete, one-cycle pulse
- dcache_read / dcache_write  in  1 each  data request, held until dcache_resp, never both high
- dcache_addr  in  32  data address
- dcache_wdata  in  32  store data
- dcache_byte_enable  in  4  store byte mask
- dcache_rdata  out  32  load data, valid when dcache_resp
- dcache_resp  out  1  data complete, one-cycle pulse
- mem_read / mem_write  out  1 each  unified-cache request
- mem_addr, mem_wdata  out  32 each  latched request address/data
- mem_byte_enable  out  4  latched mask
- mem_rdata  in  32  unified-cache read data
- mem_resp  in  1  unified-cache completion

## Operation
- act_i = icache_read; act_d = dcache_read | dcache_write.
- FSM states:
  - IDLE: drives no memory request. Selects the next port that is active and not yet done, with D priority (D belongs to the older instruction). Captures that port's addr, wdata, mask and direction into request registers, then moves to GRANT_D or GRANT_I.
  - GRANT_x: drives mem_read/mem_write from the latched direction. On mem_resp, latches mem_rdata into buf_x, sets done_x and returns to IDLE.
- cmp_x = done_x | (state==GRANT_x & mem_resp).
- advance = (act_i|act_d) & (~act_i|cmp_i) & (~act_d|cmp_d).
- icache_resp = advance & act_i; dcache_resp = advance & act_d.
- rdata outputs = buf_x if done_x, else mem_rdata (combinational pass-through on the completing cycle).
- On advance: clear done_i and done_d.
- Redirect: if icache_addr differs from the address latched for I:
  - while done_i: clear done_i; I is re-arbitrated.
  - while GRANT_I at mem_resp: discard the data and leave done_i clear.
  - In either case, icache_resp never returns stale data.
- If a request drops without a resp (only possible via rst), the arbiter abandons it.

## Timing
- Reset values: FSM=IDLE, done flags 0, buffers 0, request registers 0. All outputs 0.
- Arbitration costs 1 cycle:
  - request sampled in IDLE at cycle N; mem_* asserted at N+1.
  - with mem_resp at N+1, single-port resp at N+1.
- Two ports with a 1-cycle cache: D is granted at N+1, IDLE at N+2, I is granted at N+3. Both resps pulse at N+3.
- mem_* request signals are stable from grant until mem_resp inclusive.
- rst mid-GRANT: mem_read/mem_write are 0 on the next cycle, and the in-flight response is ignored.
- mem_resp arriving in IDLE is ignored.

## Configuration
- ARB_IFETCH_REUSE_EN defined:
  - Keeps last_i_addr, last_i_data and reuse_valid.
  - An I request whose addr equals last_i_addr while reuse_valid counts as cmp_i immediately, with rdata = last_i_data and no memory access.
  - Any granted D write clears reuse_valid if its word address (addr[31:2]) matches last_i_addr[31:2].
  - rst clears reuse_valid.
- Undefined: every I request goes to memory. Logic and state for reuse are absent.

## Test plan
- I only: icache_read=1, addr 0x60, mem_resp 1 cycle after mem_read → mem_addr=0x60 at cycle 1; icache_resp pulses with rdata=mem_rdata (0x00000013).
- Joint: I addr 0x64 plus dcache_read 0x100. D is granted first. dcache_resp is withheld until the I grant's mem_resp, then both pulse in the same cycle with buffered D data and live I data.
- Store: dcache_write addr 0x200, wdata 0xDEADBEEF, mask 4'b0011 → mem_write=1 with the same latched values, held while mem_resp is 0 for 5 cycles.
- Redirect: while done_i is set for 0x64, icache_addr changes to 0x80 → 0x80 is re-fetched, and icache_rdata equals the 0x80 data.
- Reset in GRANT_D → outputs 0 the next cycle. A late mem_resp produces no dcache_resp.
- ARB_IFETCH_REUSE_EN:
  - Repeated fetch of 0x64 after advance → icache_resp in the request cycle, mem_read stays 0.
  - After a store to 0x64, the next fetch goes to memory.
